obi_multiport_ram: RTL

Parametrised successor to the two-port simulation RAM used by the GPGPU benches. It provides NUM_PORTS independent OBI slave ports onto one word array. Each port has a configurable read latency and an optional periodic grant-stall pattern. Built-in done-word detection lets benches end a run without polling the memory hierarchically. It sits between gpgpu_top's instruction/data OBI masters and the bench; the array stays preloadable by hierarchical access.

---
 rtl/obi_ram_pkg.sv | 30 +++
 rtl/obi_ram_rsp_pipe.sv | 38 +++
 rtl/obi_multiport_ram.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/obi_ram_pkg.sv
// Shared types and helpers for the multi-port OBI simulation RAM.
package obi_ram_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    // One stage of the per-port response pipeline.
    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic              err;
    } rsp_slot_t;

    // Merge wdata into old_word on the bytes selected by be.
    function automatic logic [WORD_W-1:0] apply_be(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_ram_rsp_pipe.sv
// Fixed-latency response shift register for one OBI slave port.
module obi_ram_rsp_pipe
    import obi_ram_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  rsp_slot_t slot_i,
    output rsp_slot_t slot_o
);

    rsp_slot_t pipe_q [LATENCY];
    rsp_slot_t pipe_d [LATENCY];

    always_comb begin
        pipe_d[0] = slot_i;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign slot_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/obi_multiport_ram.sv
// Multi-port OBI slave RAM with per-port fixed read latency, optional periodic
// grant stalls, out-of-range error flagging and done-word detection.
module obi_multiport_ram
    import obi_ram_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 2,
    parameter int unsigned MEM_SIZE_WORD = 40960,
    parameter int unsigned LATENCY       = 1,
    parameter int unsigned STALL_PERIOD  = 0,
    parameter int unsigned DONE_WORD     = 40704,
    parameter logic [31:0] ERR_DATA      = 32'hDEADBEEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_PORTS-1:0]     req_i,
    input  logic [NUM_PORTS-1:0]     we_i,
    input  logic [NUM_PORTS*4-1:0]   be_i,
    input  logic [NUM_PORTS*32-1:0]  addr_i,
    input  logic [NUM_PORTS*32-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]     gnt_o,
    output logic [NUM_PORTS-1:0]     rvalid_o,
    output logic [NUM_PORTS*32-1:0]  rdata_o,
    output logic [NUM_PORTS-1:0]     err_o,
    output logic                     done_o
);

    localparam int unsigned AW = (MEM_SIZE_WORD > 1) ? $clog2(MEM_SIZE_WORD) : 1;
    localparam int unsigned CW = (STALL_PERIOD > 0) ? $clog2(STALL_PERIOD + 1) : 1;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $fatal(1, "obi_multiport_ram: LATENCY must be within 1..8");
    end
    if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
        $fatal(1, "obi_multiport_ram: NUM_PORTS must be within 1..8");
    end

    logic [WORD_W-1:0]    mem_q [MEM_SIZE_WORD];

    logic [NUM_PORTS-1:0] stall_q, stall_d;
    logic [CW-1:0]        cnt_q [NUM_PORTS];
    logic [CW-1:0]        cnt_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] err_q, err_d;
    logic                 done_q, done_d;

    logic [NUM_PORTS-1:0] acc_c;
    logic [NUM_PORTS-1:0] wr_c;
    logic [NUM_PORTS-1:0] oor_c;
    logic [29:0]          word_c    [NUM_PORTS];
    logic [AW-1:0]        idx_c     [NUM_PORTS];
    logic [WORD_W-1:0]    rd_word_c [NUM_PORTS];
    logic [WORD_W-1:0]    wr_word_c [NUM_PORTS];
    rsp_slot_t            slot_in_c [NUM_PORTS];
    rsp_slot_t            slot_out  [NUM_PORTS];

    logic [2*NUM_PORTS-1:0] unused_addr_lsb;

    assign gnt_o = req_i & ~stall_q;
    assign acc_c = req_i & gnt_o;

    // Stall counters: after STALL_PERIOD accepted transfers, hold gnt low one cycle.
    always_comb begin
        stall_d = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (STALL_PERIOD != 0 && acc_c[p]) begin
                if (cnt_q[p] == CW'(STALL_PERIOD - 1)) begin
                    cnt_d[p]   = '0;
                    stall_d[p] = 1'b1;
                end else begin
                    cnt_d[p] = cnt_q[p] + CW'(1);
                end
            end
        end
    end

    // Address decode and read sampling; reads see the array before this edge's writes.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            word_c[p]    = addr_i[32*p+2 +: 30];
            oor_c[p]     = {2'b00, word_c[p]} >= MEM_SIZE_WORD;
            idx_c[p]     = oor_c[p] ? '0 : word_c[p][AW-1:0];
            wr_c[p]      = acc_c[p] & we_i[p] & ~oor_c[p];
            rd_word_c[p] = oor_c[p] ? ERR_DATA : mem_q[idx_c[p]];
        end
    end

    // Fold every same-word write into one image so all colliding ports store the
    // same value; applying high ports first lets the lowest port win per byte.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            wr_word_c[p] = mem_q[idx_c[p]];
            for (int q = int'(NUM_PORTS) - 1; q >= 0; q--) begin
                if (wr_c[q] && idx_c[q] == idx_c[p]) begin
                    wr_word_c[p] = apply_be(wr_word_c[p], wdata_i[32*q +: 32], be_i[4*q +: 4]);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            slot_in_c[p].valid = acc_c[p];
            slot_in_c[p].data  = (acc_c[p] && !we_i[p]) ? rd_word_c[p] : '0;
            slot_in_c[p].err   = acc_c[p] & oor_c[p];
            err_d[p]           = err_q[p] | (slot_out[p].valid & slot_out[p].err);
        end
    end

    // Array has no reset so a preload survives rst_i.
    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (wr_c[p]) begin
                mem_q[idx_c[p]] <= wr_word_c[p];
            end
        end
    end

    if (DONE_WORD < MEM_SIZE_WORD) begin : g_done
        assign done_d = (mem_q[AW'(DONE_WORD)] == 32'h1);
    end else begin : g_no_done
        assign done_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
            done_q  <= done_d;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        obi_ram_rsp_pipe #(
            .LATENCY (LATENCY)
        ) u_rsp_pipe (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .slot_i (slot_in_c[p]),
            .slot_o (slot_out[p])
        );

        assign rvalid_o[p]          = slot_out[p].valid;
        assign rdata_o[32*p +: 32]  = slot_out[p].data;
        assign unused_addr_lsb[2*p +: 2] = addr_i[32*p +: 2];
    end

    assign err_o  = err_d;
    assign done_o = done_q;

endmodule
